// File: rtl/wb_arbiter.sv
// Write-back arbiter: one holding entry per execution unit, round-robin grant
// of full entries onto a single registered register-file write port.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module wb_arbiter #(
    parameter logic [1:0] ADD        = 2'b00,
    parameter logic [1:0] MULT       = 2'b01,
    parameter logic [1:0] MULADD     = 2'b10,
    localparam int        ADDR_WIDTH = `ADDR_WIDTH,
    parameter int         DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  add_valid,
    input  logic                  mult_valid,
    input  logic                  muladd_valid,
    output logic                  add_ready,
    output logic                  mult_ready,
    output logic                  muladd_ready,
    input  logic [ADDR_WIDTH-1:0] add_rd,
    input  logic [ADDR_WIDTH-1:0] mult_rd,
    input  logic [ADDR_WIDTH-1:0] muladd_rd,
    input  logic [DATA_WIDTH-1:0] add_data,
    input  logic [DATA_WIDTH-1:0] mult_data,
    input  logic [DATA_WIDTH-1:0] muladd_data,
    output logic                  wr_en,
    output logic [1:0]            rd_sel,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] wr_data
);

    // Source index 0/1/2 = ADD/MULT/MULADD throughout.
    logic [2:0]            valid_v;
    logic [2:0]            ready_v;
    logic [ADDR_WIDTH-1:0] rd_v [3];
    logic [DATA_WIDTH-1:0] data_v [3];

    logic [2:0]            full_p0;
    logic [ADDR_WIDTH-1:0] ent_rd_p0 [3];
    logic [DATA_WIDTH-1:0] ent_data_p0 [3];
    logic [1:0]            last_idx;

    logic [2:0]            gnt;
    logic                  gnt_any;
    logic [1:0]            gnt_idx;
    logic [ADDR_WIDTH-1:0] gnt_rd;
    logic [DATA_WIDTH-1:0] gnt_data;
    int                    cand;

    function automatic logic [1:0] src_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADD;
            2'd1:    return MULT;
            default: return MULADD;
        endcase
    endfunction

    assign valid_v   = {muladd_valid, mult_valid, add_valid};
    assign rd_v[0]   = add_rd;
    assign rd_v[1]   = mult_rd;
    assign rd_v[2]   = muladd_rd;
    assign data_v[0] = add_data;
    assign data_v[1] = mult_data;
    assign data_v[2] = muladd_data;

    // A full entry can accept again only on the edge that drains it.
    assign ready_v      = ~full_p0 | gnt;
    assign add_ready    = ready_v[0];
    assign mult_ready   = ready_v[1];
    assign muladd_ready = ready_v[2];

    // Round-robin search starting one past the last granted source.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        gnt_rd   = '0;
        gnt_data = '0;
        cand     = 0;
        for (int k = 1; k <= 3; k++) begin
            cand = (int'(last_idx) + k) % 3;
            for (int i = 0; i < 3; i++) begin
                if (!gnt_any && cand == i && full_p0[i]) begin
                    gnt_any  = 1'b1;
                    gnt[i]   = 1'b1;
                    gnt_idx  = 2'(i);
                    gnt_rd   = ent_rd_p0[i];
                    gnt_data = ent_data_p0[i];
                end
            end
        end
    end

    // ---- stage p0: holding entries (capture from units) ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_v[i] && ready_v[i]) begin
                ent_rd_p0[i]   <= rd_v[i];
                ent_data_p0[i] <= data_v[i];
            end
        end
    end

    // ---- stage p1: control state and registered write port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            full_p0  <= '0;
            last_idx <= 2'd2;
            wr_en    <= 1'b0;
            rd_sel   <= ADD;
            rd       <= '0;
            wr_data  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (valid_v[i] && ready_v[i])
                    full_p0[i] <= 1'b1;
                else if (gnt[i])
                    full_p0[i] <= 1'b0;
            end
            wr_en <= gnt_any;
            if (gnt_any) begin
                last_idx <= gnt_idx;
                rd_sel   <= src_code(gnt_idx);
                rd       <= gnt_rd;
                wr_data  <= gnt_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference predicts readies and
// writes; a negedge monitor pops expected writes and checks held outputs.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module tb_wb_arbiter;
    localparam int AW = `ADDR_WIDTH;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          o_valid [3];
    logic [AW-1:0] o_rd [3];
    logic [DW-1:0] o_data [3];
    logic [2:0]    rdy;
    logic          wr_en;
    logic [1:0]    rd_sel;
    logic [AW-1:0] rd;
    logic [DW-1:0] wr_data;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .add_valid(o_valid[0]), .mult_valid(o_valid[1]), .muladd_valid(o_valid[2]),
        .add_ready(rdy[0]), .mult_ready(rdy[1]), .muladd_ready(rdy[2]),
        .add_rd(o_rd[0]), .mult_rd(o_rd[1]), .muladd_rd(o_rd[2]),
        .add_data(o_data[0]), .mult_data(o_data[1]), .muladd_data(o_data[2]),
        .wr_en(wr_en), .rd_sel(rd_sel), .rd(rd), .wr_data(wr_data)
    );

    typedef struct {
        logic [1:0]    code;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            when;
    } wr_t;

    wr_t           exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;

    // Reference state: what each unit has parked, and who went last.
    bit            m_full [3];
    logic [AW-1:0] m_rd [3];
    logic [DW-1:0] m_data [3];
    int            m_last;
    bit            m_hold [3];
    logic [1:0]    h_sel;
    logic [AW-1:0] h_rd;
    logic [DW-1:0] h_data;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_full[i] = 1'b0;
            m_hold[i] = 1'b0;
        end
        m_last = 2;
    endtask

    // One clock: check readies, advance the reference, apply the edge.
    task automatic step(input bit do_rst);
        int  g;
        bit  er [3];
        @(negedge clk);
        rst = do_rst;
        g = -1;
        for (int k = 1; k <= 3; k++)
            if (g < 0 && m_full[(m_last + k) % 3]) g = (m_last + k) % 3;
        for (int i = 0; i < 3; i++) begin
            er[i] = !m_full[i] || (g == i);
            chk($sformatf("ready%0d", i), 64'(rdy[i]), 64'(er[i]));
        end
        if (do_rst) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                exp_q.push_back('{code: 2'(g), rd: m_rd[g], data: m_data[g], when: cyc + 1});
                m_full[g] = 1'b0;
                m_last = g;
            end
            for (int i = 0; i < 3; i++) begin
                m_hold[i] = o_valid[i] && !er[i];
                if (o_valid[i] && er[i]) begin
                    m_full[i] = 1'b1;
                    m_rd[i]   = o_rd[i];
                    m_data[i] = o_data[i];
                end
            end
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            h_sel = 2'b00; h_rd = '0; h_data = '0;
        end
        rst = 1'b0;
    endtask

    task automatic offer(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        if (!m_hold[i]) begin
            o_valid[i] = 1'b1; o_rd[i] = r; o_data[i] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) if (!m_hold[i]) o_valid[i] = 1'b0;
            step(1'b0);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) o_valid[i] = 1'b0;
        step(1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr_en", 64'(wr_en), 64'(0));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.when));
                    chk("wr_rd_sel", 64'(rd_sel), 64'(e.code));
                    chk("wr_rd", 64'(rd), 64'(e.rd));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                    h_sel = e.code; h_rd = e.rd; h_data = e.data;
                end
            end else begin
                chk("wr_en_low", 64'(wr_en), 64'(0));
                chk("hold_rd_sel", 64'(rd_sel), 64'(h_sel));
                chk("hold_rd", 64'(rd), 64'(h_rd));
                chk("hold_wr_data", 64'(wr_data), 64'(h_data));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            o_valid[i] = 1'b0; o_rd[i] = '0; o_data[i] = '0;
        end
        model_reset();
        h_sel = 2'b00; h_rd = '0; h_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Single ADD result, two-edge latency
        offer(0, AW'(5), 32'h11);
        step(1'b0);
        idle(4);

        // All three at once drain back to back in ADD, MULT, MULADD order
        do_reset();
        offer(0, AW'(1), 32'hA1);
        offer(1, AW'(2), 32'hB2);
        offer(2, AW'(3), 32'hC3);
        step(1'b0);
        idle(5);

        // ADD and MULT streaming continuously alternate
        do_reset();
        for (int c = 0; c < 10; c++) begin
            offer(0, AW'($urandom), $urandom);
            offer(1, AW'($urandom), $urandom);
            step(1'b0);
        end
        o_valid[0] = 1'b0; o_valid[1] = 1'b0;
        idle(4);

        // After MULADD wins, ADD outranks MULADD
        do_reset();
        offer(2, AW'(9), 32'h99);
        step(1'b0);
        idle(3);
        offer(0, AW'(4), 32'h44);
        offer(2, AW'(6), 32'h66);
        step(1'b0);
        idle(4);

        // Reset while two entries are full discards them
        do_reset();
        offer(0, AW'(10), 32'h1010);
        offer(1, AW'(11), 32'h1111);
        step(1'b0);
        o_valid[0] = 1'b0; o_valid[1] = 1'b0;
        step(1'b1);
        idle(4);

        // MULT write then long idle keeps outputs held
        offer(1, AW'(7), 32'h77);
        step(1'b0);
        idle(12);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++)
                if (!m_hold[i]) begin
                    o_valid[i] = ($urandom_range(0, 99) < 55);
                    o_rd[i]    = AW'($urandom);
                    o_data[i]  = $urandom;
                end
            step($urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < 3; i++) m_hold[i] = 1'b0;
        idle(6);

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADD, default 2'b00, meaning rd_sel code for the adder unit.
REQ-002 SHALL have parameter MULT, default 2'b01, meaning rd_sel code for the multiplier unit.
REQ-003 SHALL have parameter MULADD, default 2'b10, meaning rd_sel code for the multiply-add unit.
REQ-004 SHALL have localparam ADDR_WIDTH, default `ADDR_WIDTH, meaning register address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 32, meaning result width.
REQ-006 SHALL have port clk, input, 1, meaning sole clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-008 SHALL have ports add_valid / mult_valid / muladd_valid, input, 1 each, meaning unit presents a result.
REQ-009 SHALL have ports add_ready / mult_ready / muladd_ready, output, 1 each, meaning arbiter accepts that unit's result this cycle.
REQ-010 SHALL have ports add_rd / mult_rd / muladd_rd, input, ADDR_WIDTH each, meaning destination register.
REQ-011 SHALL have ports add_data / mult_data / muladd_data, input, DATA_WIDTH each, meaning result value.
REQ-012 SHALL have port wr_en, output, 1, meaning register-file write strobe.
REQ-013 SHALL have port rd_sel, output, 2, meaning source code of the current write (ADD/MULT/MULADD).
REQ-014 SHALL have port rd, output, ADDR_WIDTH, meaning write address.
REQ-015 SHALL have port wr_data, output, DATA_WIDTH, meaning write data.

Function
REQ-016 SHALL hold one entry per unit (full flag, rd, data).
REQ-017 SHALL complete a transfer on a rising edge where valid and ready are both 1; the entry captures rd and data and sets full.
REQ-018 SHALL drive ready combinationally as (not full) or (full and granted this cycle), so a unit can transfer every cycle while it wins arbitration.
REQ-019 SHALL grant at most one full entry per cycle, round-robin in order ADD, MULT, MULADD, starting after the last granted source.
REQ-020 SHALL, on the grant edge, clear the granted entry's full flag (unless a new transfer refills it on the same edge), and advance the last-granted pointer to the granted source.
REQ-021 SHALL register outputs: after a grant edge, wr_en=1 and rd_sel/rd/wr_data equal the granted source code and entry contents for exactly one cycle.
REQ-022 SHALL give 2-cycle minimum latency: result accepted at edge N appears with wr_en=1 after edge N+1.
REQ-023 SHALL, with no full entry, drive wr_en=0 while rd_sel, rd and wr_data hold their previous values.
REQ-024 SHALL NOT let a non-granted full entry change; its ready stays 0 and the unit holds valid/rd/data.
REQ-025 SHALL NOT grant an entry in the same edge it is first captured; capture and grant are separate edges.
REQ-026 SHALL NOT advance the pointer while idle.
REQ-027 SHALL treat valid with an unused code as impossible; only three sources exist.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, clear all full flags, set wr_en=0, rd_sel=ADD, rd=0, wr_data=0, and set the pointer to MULADD so ADD has first priority.
REQ-029 SHALL give rst priority over any simultaneous transfer or grant; entries pending at reset are discarded without a write.
REQ-030 SHALL drive all ready outputs 1 in the first cycle after reset is released.

Verification
REQ-031 SHALL pass this scenario: after reset, add_valid=1, add_rd=5, add_data=0x11 for one cycle -> two edges later wr_en=1, rd_sel=00, rd=5, wr_data=0x11 for one cycle.
REQ-032 SHALL pass this scenario: all three valid in the same cycle with rd 1/2/3 -> writes on consecutive cycles in order ADD(rd=1), MULT(rd=2), MULADD(rd=3), with no gap.
REQ-033 SHALL pass this scenario: ADD and MULT valid held continuously -> rd_sel alternates 00,01,00,01; each unit's ready is 1 only in its grant cycle.
REQ-034 SHALL pass this scenario: MULADD granted last, then ADD and MULADD both full -> ADD is granted before MULADD.
REQ-035 SHALL pass this scenario: rst asserted while two entries are full -> no wr_en pulse follows; outputs read 0/ADD and all readies read 1 after release.
REQ-036 SHALL pass this scenario: idle for 10 cycles after a MULT write of rd=7 -> wr_en=0 throughout, with rd_sel=01 and rd=7 held.
